// File: rtl/instr_sequencer.sv
// Fetch/decode/execute controller: fetches over req/ack, pulses exec_en for ALU ops, resolves jumps/halt itself.
// Latency: ALU op 4 cycles, jump/NOP 3, halt 2 (zero-wait memory); each imem wait cycle adds one.
// Backpressure: FETCH holds imem_req until imem_ack; SEQ_FETCH_TIMEOUT_EN bounds the wait and halts with fetch_err.
module instr_sequencer #(
    parameter int PC_W          = 8,
    parameter int FETCH_TIMEOUT = 16
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    output logic            imem_req,
    output logic [PC_W-1:0] imem_addr,
    input  logic            imem_ack,
    input  logic [31:0]     imem_rdata,
    output logic [31:0]     ir,
    output logic            ir_load,
    output logic            exec_en,
    input  logic            zero_flag,
    output logic [PC_W-1:0] pc,
    output logic            busy,
    output logic            halted,
    output logic            fetch_err
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_DECODE,
        S_EXEC,
        S_NEXT,
        S_HALT
    } state_t;

    localparam logic [4:0] OP_ALU_MAX = 5'b01011;
    localparam logic [4:0] OP_JMP     = 5'b01100;
    localparam logic [4:0] OP_JZ      = 5'b01101;
    localparam logic [4:0] OP_JNZ     = 5'b01110;
    localparam logic [4:0] OP_HALT    = 5'b01111;

    state_t          state;
    logic [4:0]      opcode;
    logic [PC_W-1:0] target;
    logic [PC_W-1:0] pc_inc;
    logic            take_jump;

    assign opcode    = ir[31:27];
    assign target    = ir[PC_W-1:0];
    assign pc_inc    = pc + PC_W'(1);
    assign imem_addr = pc;

    // zero_flag is only consumed in NEXT, one cycle after any exec_en pulse
    always_comb begin
        take_jump = 1'b0;
        case (opcode)
            OP_JMP:  take_jump = 1'b1;
            OP_JZ:   take_jump = zero_flag;
            OP_JNZ:  take_jump = !zero_flag;
            default: take_jump = 1'b0;
        endcase
    end

`ifdef SEQ_FETCH_TIMEOUT_EN
    localparam int TW = $clog2(FETCH_TIMEOUT + 1);
    logic [TW-1:0] tmo_cnt;
    logic          tmo_hit;
    logic          fetch_err_q;

    assign tmo_hit   = (tmo_cnt == TW'(FETCH_TIMEOUT - 1));
    assign fetch_err = fetch_err_q;
`else
    // parameter stays referenced so both builds share one interface
    assign fetch_err = 1'b0 & (FETCH_TIMEOUT == 0);
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= S_IDLE;
            pc       <= '0;
            imem_req <= 1'b0;
            ir       <= '0;
            ir_load  <= 1'b0;
            exec_en  <= 1'b0;
            busy     <= 1'b0;
            halted   <= 1'b0;
`ifdef SEQ_FETCH_TIMEOUT_EN
            tmo_cnt     <= '0;
            fetch_err_q <= 1'b0;
`endif
        end else begin
            ir_load <= 1'b0;
            exec_en <= 1'b0;
            case (state)
                S_IDLE, S_HALT: begin
                    if (start) begin
                        pc       <= '0;
                        imem_req <= 1'b1;
                        busy     <= 1'b1;
                        halted   <= 1'b0;
                        state    <= S_FETCH;
`ifdef SEQ_FETCH_TIMEOUT_EN
                        tmo_cnt     <= '0;
                        fetch_err_q <= 1'b0;
`endif
                    end
                end
                S_FETCH: begin
                    if (imem_ack) begin
                        ir       <= imem_rdata;
                        imem_req <= 1'b0;
                        ir_load  <= 1'b1;
                        state    <= S_DECODE;
                    end
`ifdef SEQ_FETCH_TIMEOUT_EN
                    else if (tmo_hit) begin
                        imem_req    <= 1'b0;
                        fetch_err_q <= 1'b1;
                        busy        <= 1'b0;
                        halted      <= 1'b1;
                        state       <= S_HALT;
                    end else begin
                        tmo_cnt <= tmo_cnt + TW'(1);
                    end
`endif
                end
                S_DECODE: begin
                    if (opcode <= OP_ALU_MAX) begin
                        exec_en <= 1'b1;
                        state   <= S_EXEC;
                    end else if (opcode == OP_HALT) begin
                        busy   <= 1'b0;
                        halted <= 1'b1;
                        state  <= S_HALT;
                    end else begin
                        state <= S_NEXT;
                    end
                end
                S_EXEC: state <= S_NEXT;
                S_NEXT: begin
                    pc       <= take_jump ? target : pc_inc;
                    imem_req <= 1'b1;
                    state    <= S_FETCH;
`ifdef SEQ_FETCH_TIMEOUT_EN
                    tmo_cnt <= '0;
`endif
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_instr_sequencer.sv
// Bench for instr_sequencer: jump/ALU/halt vector table, multi-cycle corner sequences, randomized programs vs a trace model.
`timescale 1ns/1ps
module tb_instr_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        imem_req;
    logic [7:0]  imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic [31:0] ir;
    logic        ir_load;
    logic        exec_en;
    logic        zero_flag;
    logic [7:0]  pc;
    logic        busy;
    logic        halted;
    logic        fetch_err;

    instr_sequencer #(.PC_W(8), .FETCH_TIMEOUT(16)) dut (
        .clk(clk), .rst(rst), .start(start),
        .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_ack(imem_ack), .imem_rdata(imem_rdata),
        .ir(ir), .ir_load(ir_load), .exec_en(exec_en),
        .zero_flag(zero_flag), .pc(pc),
        .busy(busy), .halted(halted), .fetch_err(fetch_err)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    logic [31:0] mem   [256];
    int          waits [256];
    logic        resp_en    = 1'b1;
    logic        manual_ack = 1'b0;
    int          wcnt       = 0;

    // instruction memory: ack after waits[addr] stall cycles of a held request
    always @(negedge clk) begin
        imem_rdata = mem[imem_addr];
        if (!resp_en) begin
            imem_ack = manual_ack;
        end else if (imem_req) begin
            imem_ack = (wcnt >= waits[imem_addr]);
            wcnt     = wcnt + 1;
        end else begin
            imem_ack = 1'b0;
            wcnt     = 0;
        end
    end

    function automatic void chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endfunction

    function automatic logic [31:0] ins(input logic [4:0] op, input logic [7:0] imm);
        return {op, 19'd0, imm};
    endfunction

    task automatic do_reset();
        rst = 1'b1;
        start = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // ---------------- trace model ----------------
    typedef struct {
        logic        req;
        logic [7:0]  addr;
        logic        ld;
        logic        ex;
        logic        bsy;
        logic        hlt;
        logic [31:0] ir;
    } cyc_t;

    cyc_t exp_q[$];
    localparam int MAXI = 24;

    function automatic cyc_t mk(input logic rq, input logic [7:0] a, input logic ld, input logic ex,
                                input logic bz, input logic hl, input logic [31:0] i);
        cyc_t c;
        c.req = rq; c.addr = a; c.ld = ld; c.ex = ex; c.bsy = bz; c.hlt = hl; c.ir = i;
        return c;
    endfunction

    // executes the program one instruction at a time, emitting the cycles each one costs
    function automatic void build_trace(input logic zf);
        logic [7:0]  p;
        logic [31:0] cur;
        logic [31:0] w;
        int          op;
        p = 8'd0;
        cur = 32'd0;
        exp_q.delete();
        for (int n = 0; n < MAXI; n++) begin
            w  = mem[p];
            op = int'(w[31:27]);
            for (int k = 0; k <= waits[p]; k++) exp_q.push_back(mk(1'b1, p, 1'b0, 1'b0, 1'b1, 1'b0, cur));
            cur = w;
            exp_q.push_back(mk(1'b0, p, 1'b1, 1'b0, 1'b1, 1'b0, cur));
            if (op == 15) begin
                exp_q.push_back(mk(1'b0, p, 1'b0, 1'b0, 1'b0, 1'b1, cur));
                return;
            end
            if (op < 12) exp_q.push_back(mk(1'b0, p, 1'b0, 1'b1, 1'b1, 1'b0, cur));
            exp_q.push_back(mk(1'b0, p, 1'b0, 1'b0, 1'b1, 1'b0, cur));
            if (op == 12 || (op == 13 && zf) || (op == 14 && !zf)) p = w[7:0];
            else p = p + 8'd1;
        end
    endfunction

    function automatic logic [31:0] rand_instr();
        int         s;
        logic [4:0] op;
        s = $urandom_range(0, 9);
        case (s)
            0, 1, 2, 3: op = 5'($urandom_range(0, 11));
            4:          op = 5'd12;
            5:          op = 5'd13;
            6:          op = 5'd14;
            7:          op = 5'd15;
            default:    op = 5'($urandom_range(16, 31));
        endcase
        return {op, 27'($urandom)};
    endfunction

    // ---------------- single-instruction vector table ----------------
    typedef struct {
        string       name;
        logic [31:0] instr;
        logic        zf;
        int          exp_cyc;
        logic [7:0]  exp_pc;
        int          exp_ex;
        logic        exp_halt;
    } vec_t;

    task automatic run_vec(input logic [31:0] i0, input logic zf, output int cyc,
                           output logic [7:0] pc_o, output int ex_n, output logic hl);
        mem[0] = i0;
        zero_flag = zf;
        do_reset();
        pulse_start();
        cyc = 0; ex_n = 0; hl = 1'b0; pc_o = 8'hxx;
        for (int k = 1; k <= 20; k++) begin
            if (k > 1 && (imem_req || halted)) begin
                cyc = k - 1; pc_o = pc; hl = halted;
                break;
            end
            ex_n += int'(exec_en);
            @(negedge clk);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        vec_t        vt[$];
        int          cyc, ex_n, exec_cyc[$], req_n, last_req, ex_at;
        logic [7:0]  pc_o;
        logic        hl, zf;

        rst = 1'b1; start = 1'b0; zero_flag = 1'b0;
        for (int a = 0; a < 256; a++) begin mem[a] = ins(5'd16, 8'd0); waits[a] = 0; end

        // reset state
        repeat (2) @(negedge clk);
        chk("reset_outputs", {imem_req, imem_addr, ir, ir_load, exec_en, pc, busy, halted, fetch_err},
            64'd0);
        rst = 1'b0;
        @(negedge clk);

        vt.push_back('{"jz_taken",     ins(5'd13, 8'h20), 1'b1, 3, 8'h20, 0, 1'b0});
        vt.push_back('{"jz_not_taken", ins(5'd13, 8'h20), 1'b0, 3, 8'h01, 0, 1'b0});
        vt.push_back('{"jnz_taken",    ins(5'd14, 8'h20), 1'b0, 3, 8'h20, 0, 1'b0});
        vt.push_back('{"jnz_not_taken",ins(5'd14, 8'h20), 1'b1, 3, 8'h01, 0, 1'b0});
        vt.push_back('{"jmp",          ins(5'd12, 8'h55), 1'b0, 3, 8'h55, 0, 1'b0});
        vt.push_back('{"alu_op",       ins(5'd3,  8'h77), 1'b1, 4, 8'h01, 1, 1'b0});
        vt.push_back('{"alu_last",     ins(5'd11, 8'h00), 1'b0, 4, 8'h01, 1, 1'b0});
        vt.push_back('{"nop",          ins(5'd16, 8'h44), 1'b1, 3, 8'h01, 0, 1'b0});
        vt.push_back('{"halt",         ins(5'd15, 8'h09), 1'b0, 2, 8'h00, 0, 1'b1});
        foreach (vt[i]) begin
            run_vec(vt[i].instr, vt[i].zf, cyc, pc_o, ex_n, hl);
            chk({vt[i].name, "_cycles"}, 64'(cyc),  64'(vt[i].exp_cyc));
            chk({vt[i].name, "_pc"},     64'(pc_o), 64'(vt[i].exp_pc));
            chk({vt[i].name, "_exec"},   64'(ex_n), 64'(vt[i].exp_ex));
            chk({vt[i].name, "_halted"}, 64'(hl),   64'(vt[i].exp_halt));
        end

        // add, sub, halt with zero-wait memory
        mem[0] = ins(5'd0, 8'd1); mem[1] = ins(5'd1, 8'd2); mem[2] = ins(5'd15, 8'd0);
        do_reset();
        pulse_start();
        exec_cyc.delete();
        for (int k = 1; k <= 40; k++) begin
            if (halted) break;
            if (exec_en) exec_cyc.push_back(k);
            @(negedge clk);
        end
        chk("prog_exec_count", 64'(exec_cyc.size()), 64'd2);
        if (exec_cyc.size() == 2) chk("prog_exec_spacing", 64'(exec_cyc[1] - exec_cyc[0]), 64'd4);
        chk("prog_halted", {halted, busy, pc}, {1'b1, 1'b0, 8'd2});

        // three wait cycles on an ALU fetch
        mem[0] = ins(5'd5, 8'd0); waits[0] = 3;
        do_reset();
        pulse_start();
        req_n = 0; last_req = 0; ex_at = 0;
        for (int k = 1; k <= 20; k++) begin
            if (imem_req && imem_addr == 8'd0) begin req_n++; last_req = k; end
            if (exec_en) ex_at = k;
            if (ex_at != 0) break;
            @(negedge clk);
        end
        chk("wait_req_cycles", 64'(req_n), 64'd4);
        chk("wait_exec_after_ack", 64'(ex_at - last_req), 64'd2);
        waits[0] = 0;

        // wrap at 0xFF and start ignored while busy
        mem[0] = ins(5'd12, 8'hFF); mem[8'hFF] = ins(5'd16, 8'h00);
        do_reset();
        pulse_start();
        repeat (3) @(negedge clk);
        chk("wrap_fetch_ff", {imem_req, imem_addr}, {1'b1, 8'hFF});
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("start_ignored_busy", {imem_req, ir_load, busy, pc}, {1'b0, 1'b1, 1'b1, 8'hFF});
        repeat (2) @(negedge clk);
        chk("wrap_fetch_00", {imem_req, imem_addr, pc}, {1'b1, 8'h00, 8'h00});

        // reset in the middle of a stalled fetch
        mem[0] = ins(5'd12, 8'h30); waits[8'h30] = 1000;
        do_reset();
        pulse_start();
        repeat (5) @(negedge clk);
        chk("midfetch_pending", {imem_req, pc, busy}, {1'b1, 8'h30, 1'b1});
        #2 rst = 1'b1;
        #1 chk("midfetch_reset", {imem_req, imem_addr, ir, ir_load, exec_en, pc, busy, halted, fetch_err},
               64'd0);
        resp_en = 1'b0; manual_ack = 1'b1;
        @(negedge clk);
        #2 rst = 1'b0;
        repeat (3) @(negedge clk);
        chk("ack_ignored_idle", {imem_req, ir, ir_load, busy, halted}, 64'd0);
        #2 manual_ack = 1'b0; resp_en = 1'b1;
        waits[8'h30] = 0;

`ifdef SEQ_FETCH_TIMEOUT_EN
        mem[0] = ins(5'd12, 8'h40); mem[8'h40] = ins(5'd15, 8'h00); waits[8'h40] = 1000;
        do_reset();
        pulse_start();
        req_n = 0;
        for (int k = 1; k <= 60; k++) begin
            if (halted) break;
            if (imem_req && imem_addr == 8'h40) req_n++;
            @(negedge clk);
        end
        chk("tmo_req_cycles", 64'(req_n), 64'd16);
        chk("tmo_state", {fetch_err, halted, imem_req, busy, pc}, {1'b1, 1'b1, 1'b0, 1'b0, 8'h40});
        waits[8'h40] = 0;
        pulse_start();
        chk("tmo_restart", {fetch_err, halted, imem_req, imem_addr}, {1'b0, 1'b0, 1'b1, 8'h00});
`endif

        // randomized programs against the trace model
        for (int r = 0; r < 30; r++) begin
            for (int a = 0; a < 256; a++) begin
                mem[a]   = rand_instr();
                waits[a] = $urandom_range(0, 2);
            end
            zf = 1'($urandom_range(0, 1));
            zero_flag = zf;
            do_reset();
            build_trace(zf);
            pulse_start();
            for (int i = 0; i < exp_q.size(); i++) begin
                if (i > 0) @(negedge clk);
                chk($sformatf("rand_r%0d_c%0d", r, i),
                    {imem_req, imem_addr, ir_load, exec_en, busy, halted, ir},
                    {exp_q[i].req, exp_q[i].addr, exp_q[i].ld, exp_q[i].ex, exp_q[i].bsy,
                     exp_q[i].hlt, exp_q[i].ir});
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/instr_sequencer.md
# instr_sequencer

Multi-cycle fetch/decode/execute controller for the 32-bit-instruction, 16-bit-GPR datapath. Fetches instructions from an instruction memory over a req/ack handshake and loads the datapath instruction register. Issues a one-cycle execute strobe for ALU/move opcodes and handles control-flow opcodes (jmp, jz, jnz, halt) itself, using the datapath zero flag. Sits between instruction memory and the ALU/register-file datapath.

## Interface
- PC_W, 8: program-counter / instruction-memory address width.
- FETCH_TIMEOUT, 16: max cycles waiting for imem_ack. Used only with SEQ_FETCH_TIMEOUT_EN.
- clk  in  1  system clock; all state changes on rising edge.
- rst  in  1  reset, asynchronous, active-high.
- start  in  1  begin execution at PC 0. Honoured in IDLE and HALT only.
- imem_req  out  1  fetch request; held high until ack.
- imem_addr  out  PC_W  fetch address; equals pc while imem_req is high.
- imem_ack  in  1  imem_rdata valid this cycle.
- imem_rdata  in  32  instruction word.
- ir  out  32  instruction register driven to the datapath.
- ir_load  out  1  one-cycle pulse, the cycle after ir changes.
- exec_en  out  1  one-cycle datapath write-enable pulse.
- zero_flag  in  1  datapath zero flag.
- pc  out  PC_W  current program counter.
- busy  out  1  high in every state except IDLE and HALT.
- halted  out  1  high in HALT.
- fetch_err  out  1  sticky fetch-timeout error; constant 0 without the macro.

## Operation
- Opcode is ir[31:27]. ALU class: 5'b00000–5'b01011. jmp 5'b01100, jz 5'b01101, jnz 5'b01110, halt 5'b01111. 5'b10000–5'b11111 are NOPs.
- Jump target is ir[PC_W-1:0], i.e. the low bits of the 16-bit immediate field.
- States: IDLE, FETCH, DECODE, EXEC, NEXT, HALT.
- IDLE: on start, pc←0 and go to FETCH.
- FETCH: imem_req=1, imem_addr=pc. On a sampled imem_ack, ir←imem_rdata and go to DECODE.
- DECODE: one cycle with ir_load=1.
  - ALU class → EXEC.
  - jmp, jz, jnz, NOP → NEXT.
  - halt → HALT; pc is not advanced.
- EXEC: exec_en=1 for one cycle, then → NEXT.
- NEXT: updates pc, then → FETCH. zero_flag is sampled in NEXT, one cycle after exec_en, so the flag reflects the previous ALU result.
  - jmp: pc←target.
  - jz: pc←target if zero_flag=1, else pc+1.
  - jnz: pc←target if zero_flag=0, else pc+1.
  - all others: pc←pc+1.
- pc increment wraps modulo 2^PC_W (all-ones → 0).
- HALT: holds pc and ir. start → pc←0, clear fetch_err, → FETCH.
- start is ignored while busy=1.
- imem_ack outside FETCH is ignored.
- Reset, asynchronous at any point including mid-fetch: all outputs return to reset values and state→IDLE. A pending fetch is abandoned.
- Reset values: pc=0, imem_addr=0, imem_req=0, ir=0, ir_load=0, exec_en=0, busy=0, halted=0, fetch_err=0.

## Timing
- imem_req asserts in the first FETCH cycle. imem_ack is sampled on the same edge, so zero-wait memory gives a 1-cycle FETCH.
- ALU instruction with zero-wait memory: 4 cycles (FETCH, DECODE, EXEC, NEXT).
- Jump and NOP: 3 cycles.
- halt: 2 cycles to reach HALT.
- Each wait cycle adds one cycle in FETCH.
- exec_en is registered and asserted for exactly one cycle per ALU instruction; never asserted for other opcodes.
- ir is stable from the DECODE cycle through the end of NEXT.
- Outputs are registered, except imem_addr, which is taken directly from pc.

## Configuration
- Macro SEQ_FETCH_TIMEOUT_EN.
- Defined: a counter runs in FETCH. If FETCH_TIMEOUT cycles pass without imem_ack:
  - imem_req drops;
  - fetch_err←1 (sticky);
  - state→HALT; pc holds the failing address.
  - The counter clears on every entry to FETCH.
- Not defined: FETCH waits indefinitely, no counter logic, fetch_err tied to 0.

## Test plan
- Reset mid-FETCH (imem_req=1): all outputs return to reset values immediately; state IDLE; later imem_ack has no effect.
- Zero-wait program add, sub, halt at addresses 0–2: exactly 2 exec_en pulses, 4 cycles apart; halted=1 with pc=2.
- Memory with 3 wait cycles on the ALU op at address 0: imem_req held 4 cycles with imem_addr=0; exec_en 2 cycles after ack.
- jz to 0x20 with zero_flag=1 → pc=0x20. Same with zero_flag=0 → pc=pc+1. jnz gives the mirror-image result.
- PC wrap: NOP at 0xFF (PC_W=8) → next fetch from 0x00. start pulsed while busy → ignored.
- With SEQ_FETCH_TIMEOUT_EN, FETCH_TIMEOUT=16, ack never given: after 16 cycles fetch_err=1, halted=1, imem_req=0. A following start clears fetch_err and refetches from 0.
